// File: rtl/mult_product_accumulator_if.sv
// Product-stream / result handshake bundle for the dot-product accumulator.
// The slave side is the accumulator; the master side feeds products and drains results.
interface mult_product_accumulator_if #(
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 32,
  parameter int VEC_LEN    = 16
);
  localparam int CNT_WIDTH = $clog2(VEC_LEN + 1);

  logic [PROD_WIDTH-1:0] prod_in;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_ovf;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  prod_in, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_ovf, out_valid
  );

  modport master (
    output prod_in, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// Accumulates signed multiplier products into a dot-product result and
// presents it on a valid/ready port, with optional saturation on overflow.
module mult_product_accumulator #(
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 32,
  parameter int VEC_LEN    = 16,
  parameter bit SATURATE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  mult_product_accumulator_if.slave io
);
  localparam int CNT_WIDTH = $clog2(VEC_LEN + 1);
  localparam int MSB = ACC_WIDTH - 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  sx;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  add_res;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  nxt_acc;
  logic [ACC_WIDTH-1:0]         res_data;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         nxt_cnt;
  logic [CNT_WIDTH-1:0]         res_cnt;
  logic                         ovf;
  logic                         add_ovf;
  logic                         nxt_ovf;
  logic                         res_ovf;
  logic                         accept;
  logic                         done;

  assign prod_s  = io.prod_in;
  assign sx      = ACC_WIDTH'(prod_s);
  assign sum     = acc + sx;
  assign add_ovf = (acc[MSB] == sx[MSB]) && (sum[MSB] != acc[MSB]);
  // Clamp toward the sign both operands share
  assign add_res = (add_ovf && SATURATE)
                 ? (acc[MSB] ? ACC_MIN : ACC_MAX)
                 : sum;

  assign io.in_ready  = (state != HOLD) && !rst;
  assign io.out_valid = (state == HOLD);
  assign io.out_data  = res_data;
  assign io.out_count = res_cnt;
  assign io.out_ovf   = res_ovf;

  assign accept = io.in_valid && io.in_ready;

  always_comb begin
    nxt_acc = sx;
    nxt_cnt = CNT_WIDTH'(1);
    nxt_ovf = 1'b0;
    if (state == ACCUM) begin
      nxt_acc = add_res;
      nxt_cnt = cnt + CNT_WIDTH'(1);
      nxt_ovf = ovf | add_ovf;
    end
  end

  assign done = io.in_last || (nxt_cnt == CNT_WIDTH'(VEC_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: if (accept) state_nxt = done ? HOLD : ACCUM;
      HOLD:        if (io.out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Result registers load only on HOLD entry so they survive the next vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      res_data <= '0;
      res_cnt  <= '0;
      res_ovf  <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= nxt_acc;
      cnt <= nxt_cnt;
      ovf <= nxt_ovf;
      if (done) begin
        res_data <= nxt_acc;
        res_cnt  <= nxt_cnt;
        res_ovf  <= nxt_ovf;
      end
    end
  end
endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: default 32-bit instance plus
// 20-bit saturating and wrapping instances fed identical streams.
module tb_mult_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_product_accumulator_if #(.PROD_WIDTH(20), .ACC_WIDTH(32), .VEC_LEN(16)) if_d ();
  mult_product_accumulator_if #(.PROD_WIDTH(20), .ACC_WIDTH(20), .VEC_LEN(16)) if_s ();
  mult_product_accumulator_if #(.PROD_WIDTH(20), .ACC_WIDTH(20), .VEC_LEN(16)) if_w ();

  mult_product_accumulator #(.PROD_WIDTH(20), .ACC_WIDTH(32), .VEC_LEN(16), .SATURATE(1'b1))
    u_d (.clk(clk), .rst(rst), .clr(clr), .io(if_d.slave));
  mult_product_accumulator #(.PROD_WIDTH(20), .ACC_WIDTH(20), .VEC_LEN(16), .SATURATE(1'b1))
    u_s (.clk(clk), .rst(rst), .clr(clr), .io(if_s.slave));
  mult_product_accumulator #(.PROD_WIDTH(20), .ACC_WIDTH(20), .VEC_LEN(16), .SATURATE(1'b0))
    u_w (.clk(clk), .rst(rst), .clr(clr), .io(if_w.slave));

  task automatic drive(input bit v, input int p, input bit l, input bit r);
    if_d.in_valid = v; if_d.prod_in = 20'(p); if_d.in_last = l; if_d.out_ready = r;
    if_s.in_valid = v; if_s.prod_in = 20'(p); if_s.in_last = l; if_s.out_ready = r;
    if_w.in_valid = v; if_w.prod_in = 20'(p); if_w.in_last = l; if_w.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product of q with per-step overflow handling at aw bits
  function automatic void model(input int q[$], input int aw, input bit sat,
                                output longint res, output bit ov);
    longint hi, lo, m, s;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -hi - 1;
    m  = longint'(1) <<< aw;
    res = 0;
    ov  = 1'b0;
    foreach (q[i]) begin
      s = res + longint'(q[i]);
      if (s > hi) begin
        ov = 1'b1; res = sat ? hi : s - m;
      end else if (s < lo) begin
        ov = 1'b1; res = sat ? lo : s + m;
      end else begin
        res = s;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    drive(0, 0, 0, 1);
    repeat (2) tick();
    checks++; if (if_d.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_d.out_valid); end
    checks++; if (if_d.out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h want 0", if_d.out_data); end
    checks++; if (if_d.out_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", if_d.out_count); end
    checks++; if (if_d.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", if_d.out_ovf); end
    rst = 1'b0;
    tick();
    checks++; if (if_d.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", if_d.in_ready); end
  endtask

  task automatic test_defaults();
    for (int i = 0; i < 16; i++) begin
      drive(1, 100, 0, 1);
      checks++; if (if_d.in_ready !== 1'b1 || if_d.out_valid !== 1'b0) begin
        errors++; $display("FAIL def_beat%0d rdy/vld got %0b/%0b want 1/0", i, if_d.in_ready, if_d.out_valid);
      end
      tick();
    end
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_valid !== 1'b1) begin errors++; $display("FAIL def_valid got %0b want 1", if_d.out_valid); end
    checks++; if (if_d.out_data !== 32'd1600) begin errors++; $display("FAIL def_data got %0d want 1600", $signed(if_d.out_data)); end
    checks++; if (if_d.out_count !== 5'd16) begin errors++; $display("FAIL def_count got %0d want 16", if_d.out_count); end
    checks++; if (if_d.out_ovf !== 1'b0) begin errors++; $display("FAIL def_ovf got %0b want 0", if_d.out_ovf); end
    checks++; if (if_d.in_ready !== 1'b0) begin errors++; $display("FAIL def_hold_ready got %0b want 0", if_d.in_ready); end
    tick();
    checks++; if (if_d.out_valid !== 1'b0 || if_d.in_ready !== 1'b1) begin
      errors++; $display("FAIL def_release vld/rdy got %0b/%0b want 0/1", if_d.out_valid, if_d.in_ready);
    end
  endtask

  task automatic test_signed();
    int e;
    e = -524286;
    drive(1, -5, 0, 1); tick();
    drive(1, 7, 0, 1); tick();
    drive(1, -524288, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_data !== 32'(e)) begin errors++; $display("FAIL signed_data got %0d want %0d", $signed(if_d.out_data), e); end
    checks++; if (if_d.out_count !== 5'd3) begin errors++; $display("FAIL signed_count got %0d want 3", if_d.out_count); end
    checks++; if (if_d.out_ovf !== 1'b0) begin errors++; $display("FAIL signed_ovf got %0b want 0", if_d.out_ovf); end
    tick();
    drive(1, 42, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_data !== 32'd42 || if_d.out_count !== 5'd1) begin
      errors++; $display("FAIL fresh_vec data/count got %0d/%0d want 42/1", $signed(if_d.out_data), if_d.out_count);
    end
    tick();
  endtask

  task automatic test_overflow();
    drive(1, 524287, 0, 1); tick();
    drive(1, 1, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_s.out_data !== 20'h7FFFF || if_s.out_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_pos data/ovf got %0h/%0b want 7ffff/1", if_s.out_data, if_s.out_ovf);
    end
    checks++; if (if_w.out_data !== 20'h80000 || if_w.out_ovf !== 1'b1) begin
      errors++; $display("FAIL wrap_pos data/ovf got %0h/%0b want 80000/1", if_w.out_data, if_w.out_ovf);
    end
    checks++; if (if_d.out_data !== 32'd524288 || if_d.out_ovf !== 1'b0) begin
      errors++; $display("FAIL wide_pos data/ovf got %0d/%0b want 524288/0", if_d.out_data, if_d.out_ovf);
    end
    tick();
    drive(1, -524288, 0, 1); tick();
    drive(1, -1, 0, 1); tick();
    drive(1, 0, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_s.out_data !== 20'h80000 || if_s.out_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_neg data/ovf got %0h/%0b want 80000/1", if_s.out_data, if_s.out_ovf);
    end
    checks++; if (if_w.out_data !== 20'h7FFFF || if_w.out_ovf !== 1'b1) begin
      errors++; $display("FAIL wrap_neg data/ovf got %0h/%0b want 7ffff/1", if_w.out_data, if_w.out_ovf);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, 11, 0, 1); tick();
    drive(1, 22, 1, 0); tick();
    drive(1, 77, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_d.out_valid !== 1'b1 || if_d.out_data !== 32'd33 ||
                    if_d.out_count !== 5'd2 || if_d.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d vld/data/cnt/rdy got %0b/%0d/%0d/%0b want 1/33/2/0",
                           i, if_d.out_valid, if_d.out_data, if_d.out_count, if_d.in_ready);
      end
      tick();
    end
    drive(1, 77, 1, 1); tick();
    checks++; if (if_d.out_valid !== 1'b0 || if_d.in_ready !== 1'b1 || if_d.out_data !== 32'd33) begin
      errors++; $display("FAIL bp_idle vld/rdy/data got %0b/%0b/%0d want 0/1/33", if_d.out_valid, if_d.in_ready, if_d.out_data);
    end
    tick();
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_valid !== 1'b1 || if_d.out_data !== 32'd77 || if_d.out_count !== 5'd1) begin
      errors++; $display("FAIL bp_pending vld/data/cnt got %0b/%0d/%0d want 1/77/1", if_d.out_valid, if_d.out_data, if_d.out_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 5, 0, 1); tick();
    end
    drive(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    checks++; if (if_d.out_valid !== 1'b0 || if_d.out_data !== 32'd0 || if_d.out_count !== 5'd0) begin
      errors++; $display("FAIL arst vld/data/cnt got %0b/%0d/%0d want 0/0/0", if_d.out_valid, if_d.out_data, if_d.out_count);
    end
    rst = 1'b0;
    tick();
    drive(1, 3, 0, 1); tick();
    drive(1, 3, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_valid !== 1'b1 || if_d.out_data !== 32'd6 || if_d.out_count !== 5'd2) begin
      errors++; $display("FAIL arst_new vld/data/cnt got %0b/%0d/%0d want 1/6/2", if_d.out_valid, if_d.out_data, if_d.out_count);
    end
    tick();
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, 0, 1); tick();
    end
    drive(1, 50, 0, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(0, 0, 0, 1);
    checks++; if (if_d.in_ready !== 1'b1 || if_d.out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_idle rdy/vld got %0b/%0b want 1/0", if_d.in_ready, if_d.out_valid);
    end
    tick();
    drive(1, 9, 1, 1); tick();
    drive(0, 0, 0, 1);
    checks++; if (if_d.out_data !== 32'd9 || if_d.out_count !== 5'd1 || if_d.out_ovf !== 1'b0) begin
      errors++; $display("FAIL clr_next data/cnt/ovf got %0d/%0d/%0b want 9/1/0", if_d.out_data, if_d.out_count, if_d.out_ovf);
    end
    tick();
    drive(1, 4, 1, 0); tick();
    drive(0, 0, 0, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (if_d.out_valid !== 1'b0 || if_d.in_ready !== 1'b1) begin
      errors++; $display("FAIL clr_hold vld/rdy got %0b/%0b want 0/1", if_d.out_valid, if_d.in_ready);
    end
  endtask

  task automatic test_random();
    int q[$];
    bit hold_exp;
    longint e_d, e_s, e_w;
    bit o_d, o_s, o_w;
    int e_cnt;
    bit v, l, r;
    int p;
    hold_exp = 1'b0;
    e_d = 0; e_s = 0; e_w = 0;
    o_d = 0; o_s = 0; o_w = 0;
    e_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      p = int'($urandom_range(0, 1048575)) - 524288;
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, p, l, r);
      checks++; if (if_d.in_ready !== !hold_exp || if_d.out_valid !== hold_exp ||
                    if_s.out_valid !== hold_exp || if_w.out_valid !== hold_exp) begin
        errors++; $display("FAIL rnd_hs cyc%0d rdy/vld got %0b/%0b want %0b/%0b",
                           cyc, if_d.in_ready, if_d.out_valid, !hold_exp, hold_exp);
      end
      if (hold_exp) begin
        checks++; if (if_d.out_data !== 32'(e_d) || if_d.out_ovf !== o_d || if_d.out_count !== 5'(e_cnt)) begin
          errors++; $display("FAIL rnd_d cyc%0d got %0d/%0b/%0d want %0d/%0b/%0d", cyc,
                             $signed(if_d.out_data), if_d.out_ovf, if_d.out_count, e_d, o_d, e_cnt);
        end
        checks++; if (if_s.out_data !== 20'(e_s) || if_s.out_ovf !== o_s) begin
          errors++; $display("FAIL rnd_s cyc%0d got %0h/%0b want %0h/%0b", cyc, if_s.out_data, if_s.out_ovf, 20'(e_s), o_s);
        end
        checks++; if (if_w.out_data !== 20'(e_w) || if_w.out_ovf !== o_w) begin
          errors++; $display("FAIL rnd_w cyc%0d got %0h/%0b want %0h/%0b", cyc, if_w.out_data, if_w.out_ovf, 20'(e_w), o_w);
        end
        if (r) hold_exp = 1'b0;
      end else if (v) begin
        q.push_back(p);
        if (l || q.size() == 16) begin
          model(q, 32, 1'b1, e_d, o_d);
          model(q, 20, 1'b1, e_s, o_s);
          model(q, 20, 1'b0, e_w, o_w);
          e_cnt = q.size();
          hold_exp = 1'b1;
          q.delete();
        end
      end
      tick();
    end
    drive(0, 0, 0, 1);
  endtask

  initial begin
    drive(0, 0, 0, 1);
    test_reset();
    test_defaults();
    test_signed();
    test_overflow();
    test_backpressure();
    test_async_reset();
    test_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Sequential stage directly downstream of the 10x10 multiplier (mult_uint10b `top`).
- Consumes the multiplier's 20-bit two's-complement product stream and accumulates VEC_LEN products (or fewer, if terminated by in_last) into a dot-product result.
- Presents the result on a valid/ready output port.
- Used to measure accuracy/energy of approximate multipliers under realistic MAC workloads.

Parameters:
- PROD_WIDTH, 20, width of the signed product input.
- ACC_WIDTH, 32, accumulator/result width; must be >= PROD_WIDTH.
- VEC_LEN, 16, maximum products per vector; must be >= 1.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
- Derived: CNT_WIDTH = clog2(VEC_LEN+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous abort; discards any partial vector.
- prod_in  input  PROD_WIDTH  signed product from multiplier.
- in_valid  input  1  prod_in valid.
- in_last  input  1  marks final product of a vector; qualified by in_valid.
- in_ready  output  1  stage can accept a product.
- out_data  output  ACC_WIDTH  signed accumulated result.
- out_count  output  CNT_WIDTH  number of products in result.
- out_ovf  output  1  overflow occurred in this vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - acc, out_data, out_count = 0; out_ovf=0; out_valid=0; in_ready=1 once rst deasserts.
- Beat accepted when in_valid && in_ready at a rising edge.
- prod_in is sign-extended to ACC_WIDTH before addition.
- Overflow is detected on the ACC_WIDTH-bit signed add: both operands have the same sign and the sum sign differs.
  - SATURATE=1: result clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: result wraps.
  - Either mode: ovf flag is set and stays sticky for the vector.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: acc<=sext(prod_in), cnt<=1, ovf<=0. Next state is HOLD if in_last or VEC_LEN==1, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept: acc<=acc+sext(prod_in) (saturated/wrapped), cnt<=cnt+1, ovf sticky. Next state is HOLD if in_last or cnt+1==VEC_LEN, else stay. No accept: hold all state.
  - HOLD: in_ready=0, out_valid=1; out_data/out_count/out_ovf driven from registers and stable. On out_ready: go to IDLE next cycle, out_valid=0. No input accepted in HOLD.
- Latency: out_valid rises on the clock edge that accepts the final beat, i.e. visible the cycle after the final beat is presented.
- Throughput: one product per cycle within a vector. Between vectors there is at least one cycle with in_ready=0 (HOLD).
- in_last is ignored when in_valid=0.
- The count limit terminates a vector even without in_last.
- clr=1 (synchronous): next state is IDLE, acc/cnt/ovf cleared, out_valid drops.
  - clr has priority over a simultaneous accept (beat dropped) and over out_ready.
- rst mid-operation: partial vector lost; the next accepted beat starts a new vector.
- out_data holds the last result after handshake until the next HOLD entry. It is only meaningful while out_valid=1.

Test Plan:
- Defaults: 16 consecutive beats prod_in=100, in_last=0, out_ready=1 -> out_valid high one cycle after 16th accept, out_data=1600, out_count=16, out_ovf=0; in_ready=0 for exactly that HOLD cycle.
- Beats -5, 7, -524288 with in_last on third -> out_data=-524286, out_count=3, out_ovf=0; next beat starts a fresh vector (acc not carried over).
- ACC_WIDTH=20, SATURATE=1, beats 524287 then 1 (in_last) -> out_data=524287, out_ovf=1. Same with SATURATE=0 -> out_data=-524288, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> out_data/out_count stable, in_ready=0, no beats consumed. Raise out_ready -> IDLE next cycle, pending beat accepted then.
- Assert rst asynchronously mid-clock after 7 beats -> out_valid/out_data/out_count go to 0 without waiting for an edge; 2 new beats of 3 with in_last -> out_data=6, out_count=2.
- clr together with an accepted beat (prod_in=50) after 4 beats of 10 -> beat dropped, state IDLE. Next vector of one beat 9 with in_last -> out_data=9, out_count=1.
